// File: rtl/case_6_acc_stream.sv
// case_6_acc_stream: frame accumulator for the case_6 signed multiplier output.
// Sums LEN sign-extended products per frame (wrapping at ACC_WIDTH bits) and
// returns one registered result per frame under ap_start/ap_done/ap_idle control.
module case_6_acc_stream #(
   parameter int DIN_WIDTH = 11,
   parameter int ACC_WIDTH = 16,
   parameter int LEN       = 8,
   parameter int CNT_WIDTH = 16
) (
   input  logic                        ap_clk,
   input  logic                        ap_rst_n,
   input  logic                        ap_start,
   output logic                        ap_done,
   output logic                        ap_idle,
   input  logic signed [DIN_WIDTH-1:0] din,
   input  logic                        din_vld,
   output logic                        din_rdy,
   output logic signed [ACC_WIDTH-1:0] dout,
   output logic                        dout_vld,
   input  logic                        dout_rdy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   // Count value held while the final product of a frame is being accepted.
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(LEN - 1);

   // Two's complement widening of a product to accumulator width.
   function automatic logic signed [ACC_WIDTH-1:0] sext_din(
      input logic signed [DIN_WIDTH-1:0] d
   );
      return ACC_WIDTH'(d);
   endfunction

   state_t                      r_state;
   state_t                      w_next;
   logic signed [ACC_WIDTH-1:0] r_acc;
   logic signed [ACC_WIDTH-1:0] r_dout;
   logic        [CNT_WIDTH-1:0] r_cnt;
   logic                        r_done;

   logic                        w_xfer;
   logic                        w_last;
   logic                        w_hs;
   logic                        w_clear;
   logic signed [ACC_WIDTH-1:0] w_sum;

   // Input transfer, final-product detection and result handshake.
   assign w_xfer = (r_state == S_ACC) && din_vld;
   assign w_last = w_xfer && (r_cnt == LAST_CNT);
   assign w_hs   = (r_state == S_OUT) && dout_rdy;
   assign w_sum  = r_acc + sext_din(din);

   // Next-state decode; w_clear marks every edge that launches a new frame.
   always_comb begin
      w_next  = r_state;
      w_clear = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (ap_start) begin
               w_next  = S_ACC;
               w_clear = 1'b1;
            end
         end
         S_ACC: begin
            if (w_last) begin
               w_next = S_OUT;
            end
         end
         S_OUT: begin
            if (dout_rdy) begin
               if (ap_start) begin
                  w_next  = S_ACC;
                  w_clear = 1'b1;
               end else begin
                  w_next = S_IDLE;
               end
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Accumulator, product counter, held frame result and done pulse.
   always_ff @(posedge ap_clk) begin
      if (!ap_rst_n) begin
         r_acc  <= '0;
         r_cnt  <= '0;
         r_dout <= '0;
         r_done <= 1'b0;
      end else begin
         r_done <= w_hs;
         if (w_clear) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (w_xfer) begin
            r_acc <= w_sum;
            r_cnt <= r_cnt + CNT_WIDTH'(1);
         end
         if (w_last) begin
            r_dout <= w_sum;
         end
      end
   end

   assign din_rdy  = (r_state == S_ACC);
   assign dout_vld = (r_state == S_OUT);
   assign ap_idle  = (r_state == S_IDLE);
   assign ap_done  = r_done;
   assign dout     = r_dout;

endmodule

// File: doc/case_6_acc_stream.md
Name: case_6_acc_stream

Overview:
Downstream consumer of the case_6 11-bit signed multiplier output. Accepts a stream of truncated signed products over a valid/ready handshake and sign-extends each one. Accumulates LEN products per frame into a wrapping accumulator, then presents one registered frame result on a valid/ready output. Frames are launched and completed through HLS-style ap_start/ap_done/ap_idle block control.

Parameters:
DIN_WIDTH, 11, width of signed product input (matches multiplier dout).
ACC_WIDTH, 16, accumulator and dout width; arithmetic wraps modulo 2^ACC_WIDTH.
LEN, 8, products per frame; legal range 1..65535.
CNT_WIDTH, 16, frame counter width; must satisfy 2^CNT_WIDTH > LEN.

Ports:
ap_clk  in  1  clock; all state updates on rising edge.
ap_rst_n  in  1  reset, synchronous, active-low.
ap_start  in  1  request to begin a frame.
ap_done  out  1  one-cycle pulse after the frame result is consumed.
ap_idle  out  1  high while in IDLE.
din  in  DIN_WIDTH  signed product from the multiplier.
din_vld  in  1  din valid.
din_rdy  out  1  block can accept din.
dout  out  ACC_WIDTH  signed frame sum.
dout_vld  out  1  dout valid.
dout_rdy  in  1  downstream accepts dout.

Behaviour:
- Reset: sampled only on a rising ap_clk edge with ap_rst_n=0.
  - State goes to IDLE; acc=0, cnt=0.
  - Outputs: dout=0, dout_vld=0, din_rdy=0, ap_done=0, ap_idle=1.
  - Reset mid-frame discards the partial sum and any pending dout; no ap_done is produced.
- All outputs are registered or decoded from the state register. There is no combinational din_vld->din_rdy or dout_rdy->dout_vld path.
- States: IDLE, ACC, OUT.
- IDLE:
  - din_rdy=0, dout_vld=0, ap_idle=1.
  - ap_start=1 at an edge: next state ACC, acc<=0, cnt<=0.
- ACC:
  - din_rdy=1, ap_idle=0.
  - A transfer occurs at an edge where din_vld=1 and din_rdy=1: acc<=acc+sext(din), cnt<=cnt+1.
  - din_vld=0 cycles (bubbles) leave acc and cnt unchanged; there is no timeout.
  - On the transfer that brings cnt to LEN:
    - dout<=acc+sext(din), truncated to ACC_WIDTH;
    - dout_vld<=1, next state OUT;
    - din_rdy drops in the following cycle, so exactly LEN inputs are taken per frame.
  - LEN=1: the first transfer goes directly to OUT.
- OUT:
  - din_rdy=0, dout_vld=1.
  - dout is held stable until the handshake completes; din_vld is ignored.
  - Handshake at an edge with dout_vld=1 and dout_rdy=1: dout_vld<=0 and ap_done<=1, so ap_done is high for exactly the next cycle.
  - ap_start is sampled at that same edge. If 1: next state ACC with acc, cnt cleared (back-to-back frame, din_rdy high in the next cycle). If 0: next state IDLE.
  - dout keeps its last value after the handshake until overwritten by the next frame.
- ap_start in ACC, or in OUT before the handshake edge, is ignored.
- Arithmetic:
  - din is two's complement and is sign-extended to ACC_WIDTH.
  - The sum wraps modulo 2^ACC_WIDTH, with no saturation and no overflow flag.
- Latency and throughput:
  - The LEN-th input accepted at edge k gives dout_vld=1 in cycle k+1.
  - With dout_rdy tied high and ap_start held high, the minimum frame period is LEN+1 cycles: LEN input cycles plus one OUT cycle.
- Invariant: din_rdy and dout_vld are never high in the same cycle.

Test Plan:
- Reset, ap_start=1, 8 x din=1023 (0x3FF), dout_rdy=1 -> dout=8184 (0x1FF8), dout_vld in the cycle after the 8th accept, ap_done one cycle later, ap_idle=1 afterwards.
- 8 x din=-1024 (0x400) -> dout=-8192 (0xE000); alternating +1023/-1024 -> dout=-4 (0xFFFC).
- ACC_WIDTH=12, 8 x din=1023 -> dout=0xFF8 (-8, wrap); LEN=1, din=-5 -> dout=0xFFFB (default 16-bit width), dout_vld 1 cycle after accept.
- Backpressure and bubbles:
  - din_vld toggles 1,0,0,1,... -> sum is unaffected by bubbles.
  - dout_rdy low 5 cycles -> dout and dout_vld held stable, din_rdy=0, no ap_done until the handshake.
- ap_start held high, 3 frames of din=1,2,3 (each constant over its frame) -> dout=8,16,24; frames separated by exactly one OUT cycle; ap_done pulses 3 times; ap_idle stays 0.
- ap_rst_n=0 for 1 edge after 4 accepts of din=100 -> all outputs at reset values. A new frame of 8 x din=1 then yields dout=8, not 408.
